pid_regulator_v2: RTL and testbench
===================================

Name: pid_regulator_v2

Overview:
Second-generation e-bike assist PID regulator. It is parametrised in error, output, integrator and decimator widths, and in derivative history depth. It adds runtime P/D gains, an explicit sample-valid input, an integrator-saturation flag, a two-stage pipeline with an output-valid strobe, and a per-tick output slew limiter. It sits between the torque/cadence error computation and the motor-drive PWM/commutation logic.

Parameters:
ERR_W, 13, signed error width
OUT_W, 12, unsigned drive magnitude width
INT_W, 18, integrator width; the usable positive range is INT_W-1 bits
DEC_W, 20, decimator counter width; a tick occurs when all bits are 1
D_DEPTH, 2, number of ticks between the current error and the derivative's previous error (>=1)
FAST_SIM, 0, when 1 the tick uses only the low min(15,DEC_W) counter bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
error  in  ERR_W  signed error sample
err_vld  in  1  capture strobe for error
not_pedaling  in  1  synchronous clear of regulator state
kp  in  4  unsigned P gain, units of 1/4 (kp=4 means 1.0)
kd  in  4  unsigned D gain, integer multiplier
slew_lim  in  OUT_W  maximum drv_mag change per tick; 0 disables the limit
drv_mag  out  OUT_W  regulated drive magnitude
drv_vld  out  1  one-cycle pulse when drv_mag is updated
i_sat  out  1  high while the integrator sits at its positive clamp

Behaviour:
- Reset: err_q, integrator, decimator, history, stage-1 terms, drv_mag, drv_vld and i_sat are all 0.
- err_q captures error on any clk with err_vld=1 and holds otherwise.
- If err_vld and tick coincide, the tick uses the pre-update err_q.
- Decimator free-runs and wraps. tick = &dec[DEC_W-1:0], or &dec[min(15,DEC_W)-1:0] when FAST_SIM=1.
- On tick (cycle T), stage 1 registers at T+1:
  - P = (sext(err_q) * kp) >>> 2, arithmetic shift.
  - Integrator: sum = integrator + sext(err_q). If sum < 0, the integrator becomes 0. If sum > 2^(INT_W-1)-1, it becomes 2^(INT_W-1)-1. Otherwise it becomes sum.
  - I = integrator[INT_W-2 -: OUT_W], taken from the pre-update integrator value.
  - Dd = err_q - hist[D_DEPTH-1], saturated to signed 9 bits [-256, 255]. D = Dd_sat * kd.
  - History shifts: hist[0] <= err_q, hist[k] <= hist[k-1].
- Stage 2 (T+2):
  - raw = P + I + D in signed OUT_W+4 bits, clamped to [0, 2^OUT_W-1].
  - Slew limiter: if slew_lim=0 or |raw - drv_mag| <= slew_lim, drv_mag <= raw. Otherwise drv_mag moves toward raw by exactly slew_lim.
  - drv_vld = 1 for exactly the cycle T+2.
- i_sat is registered: 1 when the integrator equals 2^(INT_W-1)-1.
- not_pedaling=1 on any clk:
  - The next edge clears integrator, hist, stage-1 terms and i_sat, and forces drv_mag to 0 with no slew.
  - drv_vld=0, and any tick pipeline in flight is discarded.
  - The decimator keeps running.
- Release of not_pedaling: the regulator resumes from a zero state at the next tick.
- kp, kd and slew_lim are sampled at use: kp and kd in stage 1, slew_lim in stage 2. They may change at any time.
- Latency: tick to drv_mag/drv_vld is 2 clocks. A tick period of at least 3 clocks is required (DEC_W>=2).

Decomposition:
- Package pid_v2_pkg holds:
  - D_SAT_W = 9
  - GAIN_W = 4
  - KP_FRAC = 2
  - function sat_s2s (signed saturation to N bits)
  - function clamp_u (signed-to-unsigned clamp)
- Sub-module pid_slew_lim: (clk, rst_n, clr, en, target, slew_lim) -> (drv_mag, drv_vld). It implements stage 2 and the clamp.

Test Plan:
All scenarios use DEC_W=4 (tick every 16 clk), INT_W=18, OUT_W=12.
- Reset and idle, error=0 -> drv_mag=0 and i_sat=0 always; drv_vld pulses 2 clk after each tick.
- kp=4, kd=0, slew_lim=0, error=100 held -> after 1st tick drv_mag=100; after 2nd tick 103 (I=100>>5); integrator grows by 100 per tick.
- error=-500, kp=4 -> integrator stays 0; raw negative -> drv_mag=0.
- error=4095 held for 40 ticks -> integrator=0x1FFFF, i_sat=1, I=4095, drv_mag=4095 (clamped).
- kp=0, kd=2, D_DEPTH=2, error steps 0->50 before tick 1 -> drv_mag=100, 101, 3 on ticks 1-3; error step +3000 -> Dd saturates to 255, D=510.
- slew_lim=16, raw target 103 from drv_mag=0 -> drv_mag=16,32,48,64,80,96,103 on successive ticks; asserting not_pedaling mid-ramp -> drv_mag=0 next clk, integrator=0, no drv_vld.

Source files
------------

// File: rtl/pid_v2_pkg.sv
// Shared constants and saturation helpers for the second-generation assist PID regulator.
package pid_v2_pkg;

    // Derivative difference is saturated to this many signed bits before the gain.
    localparam int D_SAT_W = 9;
    // Width of the runtime kp/kd gain inputs.
    localparam int GAIN_W  = 4;
    // kp carries this many fractional bits (kp=4 means a gain of 1.0).
    localparam int KP_FRAC = 2;

    // Saturate a signed value to the signed range of n bits; result stays 32 bits wide.
    function automatic logic signed [31:0] sat_s2s(input logic signed [31:0] v, input int n);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (n - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (n - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^n-1]; result stays 32 bits wide.
    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int n);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< n) - 32'sd1;
        if (v < 32'sd0) begin
            return '0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_slew_lim.sv
// Output stage: clamps the summed PID term to the drive range and limits its change per tick.
module pid_slew_lim
    import pid_v2_pkg::*;
#(
    parameter int OUT_W = 12,
    parameter int SUM_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [SUM_W-1:0] target,
    input  logic [OUT_W-1:0]        slew_lim,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld
);

    logic [31:0]      raw_u;
    logic [31:0]      cur_u;
    logic [31:0]      lim_u;
    logic [31:0]      delta;
    logic [OUT_W-1:0] mag_d;

    // Clamp the target, then step toward it by at most slew_lim (0 means jump straight there).
    always_comb begin
        raw_u = clamp_u(32'(target), OUT_W);
        cur_u = 32'(drv_mag);
        lim_u = 32'(slew_lim);
        delta = (raw_u >= cur_u) ? (raw_u - cur_u) : (cur_u - raw_u);
        mag_d = OUT_W'(raw_u);
        if (slew_lim != '0 && delta > lim_u) begin
            // Moving toward raw by slew_lim never crosses raw, so this cannot wrap.
            if (raw_u > cur_u) begin
                mag_d = drv_mag + slew_lim;
            end else begin
                mag_d = drv_mag - slew_lim;
            end
        end
    end

    // Drive register: cleared without slew by clr, updated and strobed when stage 1 is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_mag <= '0;
            drv_vld <= 1'b0;
        end else if (clr) begin
            drv_mag <= '0;
            drv_vld <= 1'b0;
        end else begin
            drv_vld <= en;
            if (en) begin
                drv_mag <= mag_d;
            end
        end
    end

endmodule

// File: rtl/pid_regulator_v2.sv
// E-bike assist PID regulator: decimated tick, P/I/D stage-1 terms, clamped and slew-limited drive.
module pid_regulator_v2
    import pid_v2_pkg::*;
#(
    parameter int ERR_W    = 13,
    parameter int OUT_W    = 12,
    parameter int INT_W    = 18,
    parameter int DEC_W    = 20,
    parameter int D_DEPTH  = 2,
    parameter int FAST_SIM = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    err_vld,
    input  logic                    not_pedaling,
    input  logic [GAIN_W-1:0]       kp,
    input  logic [GAIN_W-1:0]       kd,
    input  logic [OUT_W-1:0]        slew_lim,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld,
    output logic                    i_sat
);

    // Simulation builds shorten the tick period by watching only the low counter bits.
    localparam int TICK_W = (FAST_SIM != 0 && DEC_W > 15) ? 15 : DEC_W;
    // Widths of the registered stage-1 terms and the stage-2 sum.
    localparam int P_W    = ERR_W + GAIN_W + 1;
    localparam int D_W    = D_SAT_W + GAIN_W + 1;
    localparam int SUM_W  = OUT_W + 4;
    // Positive clamp of the integrator; it never goes negative, so the top bit stays 0.
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};

    logic [DEC_W-1:0]         dec;
    logic                     tick;
    logic signed [ERR_W-1:0]  err_q;
    logic [INT_W-1:0]         integ;
    logic [INT_W-1:0]         integ_d;
    logic signed [31:0]       isum;
    logic signed [31:0]       dd;
    logic signed [D_SAT_W-1:0] dd_sat;
    logic signed [ERR_W-1:0]  hist [D_DEPTH];
    logic signed [P_W-1:0]    p_d;
    logic signed [P_W-1:0]    p_q;
    logic [OUT_W-1:0]         i_q;
    logic signed [D_W-1:0]    d_d;
    logic signed [D_W-1:0]    d_q;
    logic                     s1_vld;
    logic signed [SUM_W-1:0]  target;

    assign tick = &dec[TICK_W-1:0];

    // Free-running decimator; not_pedaling does not disturb the tick cadence.
    // NOTE: clocked state always uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec <= '0;
        end else begin
            dec <= dec + DEC_W'(1);
        end
    end

    // Error capture register; a tick on the same edge still sees the previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_vld) begin
            err_q <= error;
        end
    end

    // Stage-1 arithmetic: scaled P, saturating integrator update and saturated derivative difference.
    // NOTE: every signal driven here is fully assigned on every path, so no latch can be inferred.
    always_comb begin
        p_d  = (P_W'(err_q) * P_W'($signed({1'b0, kp}))) >>> KP_FRAC;

        isum = $signed(32'(integ)) + 32'(err_q);
        if (isum < 32'sd0) begin
            integ_d = '0;
        end else if (isum > $signed(32'(INT_MAX))) begin
            integ_d = INT_MAX;
        end else begin
            integ_d = INT_W'(isum);
        end

        dd     = 32'(err_q) - 32'(hist[D_DEPTH-1]);
        dd_sat = D_SAT_W'(sat_s2s(dd, D_SAT_W));
        d_d    = D_W'(dd_sat) * D_W'($signed({1'b0, kd}));
    end

    // Stage-1 registers, integrator, history and saturation flag; all cleared while not pedaling.
    // NOTE: hist is a short shift register built from flops, not a RAM, so it takes the reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ  <= '0;
            i_sat  <= 1'b0;
            p_q    <= '0;
            i_q    <= '0;
            d_q    <= '0;
            s1_vld <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else if (not_pedaling) begin
            integ  <= '0;
            i_sat  <= 1'b0;
            p_q    <= '0;
            i_q    <= '0;
            d_q    <= '0;
            s1_vld <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else if (tick) begin
            integ   <= integ_d;
            i_sat   <= (integ_d == INT_MAX);
            p_q     <= p_d;
            // I term comes from the integrator value before this tick's update.
            i_q     <= integ[INT_W-2 -: OUT_W];
            d_q     <= d_d;
            s1_vld  <= 1'b1;
            hist[0] <= err_q;
            for (int k = 1; k < D_DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
        end else begin
            s1_vld <= 1'b0;
        end
    end

    // Stage-2 sum of the registered terms in OUT_W+4 signed bits.
    assign target = SUM_W'(p_q) + SUM_W'($signed({1'b0, i_q})) + SUM_W'(d_q);

    pid_slew_lim #(
        .OUT_W (OUT_W),
        .SUM_W (SUM_W)
    ) u_slew (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (not_pedaling),
        .en       (s1_vld),
        .target   (target),
        .slew_lim (slew_lim),
        .drv_mag  (drv_mag),
        .drv_vld  (drv_vld)
    );

endmodule

// File: tb/tb_pid_regulator_v2.sv
// Scoreboard bench for pid_regulator_v2 with DEC_W=4 (one tick every 16 clocks).
module tb_pid_regulator_v2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [12:0] error;
    logic               err_vld;
    logic               not_pedaling;
    logic [3:0]         kp;
    logic [3:0]         kd;
    logic [11:0]        slew_lim;
    logic [11:0]        drv_mag;
    logic               drv_vld;
    logic               i_sat;

    typedef struct {
        logic [11:0] mag;
        logic        isat;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges    = 0;
    int   tick_no  = 0;

    pid_regulator_v2 #(
        .ERR_W    (13),
        .OUT_W    (12),
        .INT_W    (18),
        .DEC_W    (4),
        .D_DEPTH  (2),
        .FAST_SIM (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .error        (error),
        .err_vld      (err_vld),
        .not_pedaling (not_pedaling),
        .kp           (kp),
        .kd           (kd),
        .slew_lim     (slew_lim),
        .drv_mag      (drv_mag),
        .drv_vld      (drv_vld),
        .i_sat        (i_sat)
    );

    always #5 clk = ~clk;

    // Count rising edges since reset release; the DUT decimator equals edges mod 16.
    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every drv_vld pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && drv_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_drv_vld: got drv_mag %0d with nothing expected (t=%0t)", drv_mag, $time);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("drv_mag[tick %0d]", e.tag), 32'(drv_mag), 32'(e.mag));
                check($sformatf("i_sat[tick %0d]", e.tag), 32'(i_sat), 32'(e.isat));
            end
        end
    end

    // Apply inputs for the next tick, queue its expected result, and wait past its stage-2 edge.
    task automatic step(input logic signed [12:0] e, input logic v, input logic [3:0] p,
                        input logic [3:0] d, input logic [11:0] s, input int exp_mag,
                        input logic exp_sat);
        exp_t x;
        error    = e;
        err_vld  = v;
        kp       = p;
        kd       = d;
        slew_lim = s;
        tick_no++;
        x.mag  = 12'(exp_mag);
        x.isat = exp_sat;
        x.tag  = tick_no;
        exp_q.push_back(x);
        while (edges < 16 * tick_no + 1) @(negedge clk);
    endtask

    // One-cycle not_pedaling pulse between ticks; the drive and flags must clear on the next edge.
    task automatic np_pulse(input string tag);
        not_pedaling = 1'b1;
        @(negedge clk);
        check({tag, "_drv_mag"}, 32'(drv_mag), 32'd0);
        check({tag, "_drv_vld"}, 32'(drv_vld), 32'd0);
        check({tag, "_i_sat"}, 32'(i_sat), 32'd0);
        not_pedaling = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at tick %0d", tick_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vld_seen;
        rst_n        = 1'b0;
        error        = '0;
        err_vld      = 1'b1;
        not_pedaling = 1'b0;
        kp           = 4'd4;
        kd           = 4'd0;
        slew_lim     = '0;
        repeat (3) @(negedge clk);
        check("reset_drv_mag", 32'(drv_mag), 32'd0);
        check("reset_drv_vld", 32'(drv_vld), 32'd0);
        check("reset_i_sat", 32'(i_sat), 32'd0);
        rst_n = 1'b1;

        // Idle with zero error.
        step(0, 1, 4, 0, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0, 0);

        // P=1.0, error 100 held: integrator grows by 100 per tick, I = integ>>5.
        step(100, 1, 4, 0, 0, 100, 0);
        step(100, 1, 4, 0, 0, 103, 0);
        step(100, 1, 4, 0, 0, 106, 0);

        // Negative error: integrator floors at 0 and the drive clamps at 0.
        step(-500, 1, 4, 0, 0, 0, 0);
        step(-500, 1, 4, 0, 0, 0, 0);

        // Full-scale error: drive clamps at 4095, integrator reaches 0x1FFFF on the 33rd tick.
        for (int k = 1; k <= 40; k++) begin
            step(4095, 1, 4, 0, 0, 4095, (k >= 33));
        end
        // I alone at the clamp is 4095; i_sat falls and rises with the integrator.
        step(0, 1, 0, 0, 0, 4095, 1);
        step(-31, 1, 0, 0, 0, 4095, 0);
        step(31, 1, 0, 0, 0, 4095, 1);
        np_pulse("np_after_sat");

        // Derivative, kd=2, history depth 2, from a cleared state.
        step(50, 1, 0, 2, 0, 100, 0);
        step(50, 1, 0, 2, 0, 101, 0);
        step(50, 1, 0, 2, 0, 3, 0);
        step(3050, 1, 0, 2, 0, 514, 0);
        step(3050, 1, 0, 2, 0, 610, 0);
        step(-1000, 1, 0, 3, 0, 0, 0);
        np_pulse("np_after_d");

        // Slew limiting toward a constant target of 103 (integrator preloaded to 3296).
        step(3296, 1, 0, 0, 16, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 0, 0, 16, 16 * k, 0);
        end
        step(0, 1, 0, 0, 16, 103, 0);
        step(-3296, 1, 0, 0, 40, 103, 0);
        step(0, 1, 0, 0, 40, 63, 0);
        step(0, 1, 0, 0, 40, 23, 0);
        step(0, 1, 0, 0, 40, 0, 0);

        // Ramp again and drop not_pedaling across a whole tick mid-ramp.
        step(3296, 1, 0, 0, 16, 0, 0);
        step(0, 1, 0, 0, 16, 16, 0);
        step(0, 1, 0, 0, 16, 32, 0);
        not_pedaling = 1'b1;
        @(negedge clk);
        check("np_hold_drv_mag", 32'(drv_mag), 32'd0);
        vld_seen = 0;
        tick_no++;
        while (edges < 16 * tick_no + 1) begin
            @(negedge clk);
            if (drv_vld) vld_seen++;
        end
        check("np_hold_no_drv_vld", 32'(vld_seen), 32'd0);
        not_pedaling = 1'b0;

        // Resume from zero state, then fractional kp and a held err_q.
        step(100, 1, 4, 0, 0, 100, 0);
        step(100, 1, 4, 0, 0, 103, 0);
        step(100, 1, 4, 0, 0, 106, 0);
        step(-9, 1, 3, 0, 0, 2, 0);
        step(50, 1, 7, 0, 0, 96, 0);
        step(-4000, 0, 4, 0, 0, 60, 0);
        err_vld = 1'b1;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
